// File: rtl/lcd_cmd_seq_if.sv
// Host / LCD-controller signal bundle for lcd_cmd_seq.
// The slave modport is the sequencer's view; master is the host/controller side.
interface lcd_cmd_seq_if;
    logic [2:0] host_cmd;
    logic       host_wr;
    logic       img_we;
    logic [5:0] img_addr;
    logic [7:0] img_wdata;
    logic       busy;
    logic       output_valid;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [7:0] datain;
    logic       fifo_full;
    logic       fifo_empty;
    logic       cmd_err;
    logic       frame_done;
    logic       timeout_err;

    modport master (
        output host_cmd, host_wr, img_we, img_addr, img_wdata, busy, output_valid,
        input  cmd, cmd_valid, datain, fifo_full, fifo_empty, cmd_err, frame_done, timeout_err
    );

    modport slave (
        input  host_cmd, host_wr, img_we, img_addr, img_wdata, busy, output_valid,
        output cmd, cmd_valid, datain, fifo_full, fifo_empty, cmd_err, frame_done, timeout_err
    );
endinterface

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: queues host commands, issues them one at a time to an LCD
// controller, streams the 6x6 image buffer after a Load command and waits
// for the controller's 9-pixel output window (with a sticky timeout).
// All outputs come straight from flops; their next values are computed from
// the FSM's next state so they line up with the state register.
module lcd_cmd_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic         clk,
    input  logic         reset,
    lcd_cmd_seq_if.slave bus
);
    localparam int                PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]        WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [5:0]        PIX_LAST  = 6'd35;
    localparam logic [3:0]        OV_DONE   = 4'd9;
    localparam logic [2:0]        CMD_MAX   = 3'd5;
    localparam logic [2:0]        CMD_LOAD  = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_STREAM = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // FIFO
    logic [2:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [2:0]       fifo_head_s;

    // Image buffer
    logic [7:0]       img_buf_r [36];
    logic             img_wr_s;
    logic             img_err_s;
    logic             cmd_err_s;

    // FSM and counters
    state_t           state_r;
    state_t           state_next_s;
    logic [5:0]       pix_cnt_r;
    logic [5:0]       pix_next_s;
    logic [3:0]       ov_cnt_r;
    logic [3:0]       ov_next_s;
    logic [7:0]       wait_cnt_r;
    logic [7:0]       wait_next_s;
    logic             frame_done_s;
    logic             timeout_set_s;
    logic [7:0]       datain_next_s;

    // Output registers
    logic [2:0]       cmd_r;
    logic             cmd_valid_r;
    logic [7:0]       datain_r;
    logic             fifo_full_r;
    logic             fifo_empty_r;
    logic             cmd_err_r;
    logic             frame_done_r;
    logic             timeout_err_r;

    assign full_s      = (count_r == FULL_CNT);
    assign push_s      = bus.host_wr && (bus.host_cmd <= CMD_MAX) && !full_s;
    assign pop_s       = (state_r == ST_ISSUE);
    assign fifo_head_s = fifo_mem_r[rd_ptr_r];

    // The buffer is frozen while it is being streamed out.
    assign img_wr_s  = bus.img_we && (bus.img_addr <= PIX_LAST) && (state_r != ST_STREAM);
    assign img_err_s = bus.img_we && (state_r == ST_STREAM);
    assign cmd_err_s = (bus.host_wr && ((bus.host_cmd > CMD_MAX) || full_s)) || img_err_s;

    // Next FIFO occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage and pointers; pops only happen in ISSUE so the head is stable in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 3'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= bus.host_cmd;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
        end
    end

    // 6x6 image buffer, cleared on reset, written by the host outside STREAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 36; i++) begin
                img_buf_r[i] <= 8'd0;
            end
        end else if (img_wr_s) begin
            img_buf_r[bus.img_addr] <= bus.img_wdata;
        end
    end

    // Next-state logic and counter updates for the issue/stream/wait sequencer.
    always_comb begin
        state_next_s  = state_r;
        pix_next_s    = pix_cnt_r;
        ov_next_s     = ov_cnt_r;
        wait_next_s   = wait_cnt_r;
        frame_done_s  = 1'b0;
        timeout_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((count_r != '0) && !bus.busy && !timeout_err_r) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                pix_next_s  = 6'd0;
                ov_next_s   = 4'd0;
                wait_next_s = 8'd0;
                if (fifo_head_s == CMD_LOAD) begin
                    state_next_s = ST_STREAM;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_STREAM: begin
                if (pix_cnt_r == PIX_LAST) begin
                    pix_next_s   = 6'd0;
                    state_next_s = ST_WAIT;
                end else begin
                    pix_next_s   = pix_cnt_r + 6'd1;
                end
            end
            ST_WAIT: begin
                if (bus.output_valid && (ov_cnt_r != OV_DONE)) begin
                    ov_next_s = ov_cnt_r + 4'd1;
                end else begin
                    ov_next_s = ov_cnt_r;
                end
                // A completed window wins over a timeout in the same cycle.
                if ((ov_cnt_r == OV_DONE) && !bus.busy) begin
                    state_next_s = ST_IDLE;
                    frame_done_s = 1'b1;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s  = ST_IDLE;
                    timeout_set_s = 1'b1;
                end else begin
                    wait_next_s = wait_cnt_r + 8'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Pixel presented in the cycle the FSM will be in next.
    always_comb begin
        datain_next_s = 8'd0;
        if (state_next_s == ST_STREAM) begin
            datain_next_s = img_buf_r[pix_next_s];
        end else begin
            datain_next_s = 8'd0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            pix_cnt_r  <= 6'd0;
            ov_cnt_r   <= 4'd0;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_next_s;
            pix_cnt_r  <= pix_next_s;
            ov_cnt_r   <= ov_next_s;
            wait_cnt_r <= wait_next_s;
        end
    end

    // Registered outputs; frame_done lands in the first IDLE cycle after WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_r         <= 3'd0;
            cmd_valid_r   <= 1'b0;
            datain_r      <= 8'd0;
            fifo_full_r   <= 1'b0;
            fifo_empty_r  <= 1'b1;
            cmd_err_r     <= 1'b0;
            frame_done_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            if (state_next_s == ST_ISSUE) begin
                cmd_r <= fifo_head_s;
            end
            cmd_valid_r   <= (state_next_s == ST_ISSUE);
            datain_r      <= datain_next_s;
            fifo_full_r   <= (count_next_s == FULL_CNT);
            fifo_empty_r  <= (count_next_s == '0);
            cmd_err_r     <= cmd_err_s;
            frame_done_r  <= frame_done_s;
            timeout_err_r <= timeout_err_r | timeout_set_s;
        end
    end

    assign bus.cmd         = cmd_r;
    assign bus.cmd_valid   = cmd_valid_r;
    assign bus.datain      = datain_r;
    assign bus.fifo_full   = fifo_full_r;
    assign bus.fifo_empty  = fifo_empty_r;
    assign bus.cmd_err     = cmd_err_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.timeout_err = timeout_err_r;
endmodule

// File: doc/lcd_cmd_seq.md
LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command FIFO entries, power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 64: max cycles in WAIT before timeout, range 16..255.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 host_cmd  input  3  command code (0 Reflash, 1 Load, 2 Right, 3 Left, 4 Up, 5 Down).
REQ-006 host_wr  input  1  push host_cmd into FIFO this cycle.
REQ-007 img_we  input  1  write image buffer this cycle.
REQ-008 img_addr  input  6  image buffer address, 0..35, row-major 6x6.
REQ-009 img_wdata  input  8  image buffer write data.
REQ-010 busy  input  1  LCD controller busy.
REQ-011 output_valid  input  1  LCD controller pixel-out strobe.
REQ-012 cmd  output  3  command to LCD controller.
REQ-013 cmd_valid  output  1  command strobe to LCD controller, one cycle per command.
REQ-014 datain  output  8  pixel stream to LCD controller.
REQ-015 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-016 fifo_empty  output  1  FIFO holds 0 entries.
REQ-017 cmd_err  output  1  one-cycle pulse: host push rejected.
REQ-018 frame_done  output  1  one-cycle pulse: LCD completed one command's 9-pixel window.
REQ-019 timeout_err  output  1  sticky: WAIT exceeded TIMEOUT cycles.

Function
REQ-020 Image buffer SHALL be 36 x 8 bits, written synchronously when img_we=1 and img_addr<=35; img_addr>35 SHALL be ignored.
REQ-021 img_we during STREAM SHALL be ignored and pulse cmd_err the next cycle.
REQ-022 Push SHALL occur when host_wr=1, host_cmd<=5 and FIFO not full at that cycle's start; no same-cycle pop bypass.
REQ-023 host_wr with host_cmd 6/7, or with FIFO full, SHALL drop the command and pulse cmd_err the next cycle.
REQ-024 Simultaneous push and pop on non-full FIFO SHALL both take effect, count unchanged.
REQ-025 States: IDLE, ISSUE, STREAM, WAIT.
REQ-026 IDLE -> ISSUE when FIFO non-empty, busy=0 and timeout_err=0.
REQ-027 ISSUE (one cycle): cmd_valid=1, cmd=FIFO head, head popped at cycle end; next STREAM if cmd=1, else WAIT.
REQ-028 STREAM: datain SHALL present buffer[k] in the k-th cycle after the ISSUE cycle, k=0..35 (first pixel in the cycle immediately following cmd_valid), 36 cycles exactly, then WAIT.
REQ-029 Outside STREAM datain SHALL hold 0; outside ISSUE cmd_valid=0 and cmd holds last issued value.
REQ-030 WAIT: 4-bit counter SHALL count output_valid high cycles (saturate at 9); exit to IDLE when count=9 and busy=0, pulsing frame_done on the exit cycle.
REQ-031 WAIT cycle counter SHALL start at 0 on entry; reaching TIMEOUT without exit SHALL set timeout_err and go IDLE with no frame_done.
REQ-032 timeout_err SHALL clear only on reset; while set, no further commands issue; FIFO still accepts pushes.
REQ-033 output_valid/busy outside WAIT SHALL be ignored.
REQ-034 Minimum spacing: next cmd_valid no earlier than the cycle after frame_done.

Reset
REQ-035 Reset SHALL force IDLE, cmd=0, cmd_valid=0, datain=0, fifo_empty=1, fifo_full=0, cmd_err=0, frame_done=0, timeout_err=0, counters 0, FIFO emptied.
REQ-036 Image buffer contents SHALL be cleared to 0 on reset.
REQ-037 Reset mid-STREAM or mid-WAIT SHALL abort immediately; no cmd_valid until a new push after reset release.

Verification
REQ-038 Write buffer[i]=i, push 1; model controller -> one cmd_valid with cmd=1, datain 0..35 on the 36 following cycles, frame_done after 9 output_valid and busy=0.
REQ-039 Push 2,3,4,5 back-to-back with FIFO_DEPTH=4 -> fifo_full=1 after 4th; 5th push -> cmd_err pulse, dropped; commands issued in order 2,3,4,5, each only after previous frame_done.
REQ-040 Push host_cmd=7 -> cmd_err pulse, fifo_empty stays 1, no cmd_valid.
REQ-041 Push 0 with controller never raising output_valid -> timeout_err=1 at TIMEOUT cycles after WAIT entry; later pushes queue but never issue.
REQ-042 img_we at addr 5 during STREAM cycle 2 -> cmd_err pulse, buffer[5] unchanged on next Load.
REQ-043 Assert reset at STREAM cycle 10 -> all outputs at reset values, datain=0, no frame_done, FIFO empty.
